mul_seq_nbit: RTL

Iterative shift-add integer multiplier with valid/ready handshakes on input and output. It is the parametrised successor to the combinational WIDTH-bit low-product multiplier. It adds per-transaction signed/unsigned mode and an optional high product half, and computes one multiplier bit per clock. It sits between the operand source and the result consumer in PIM arithmetic benchmarks, where area is traded for latency.

---
 rtl/mul_seq_nbit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_seq_nbit.sv
// mul_seq_nbit: iterative shift-add multiplier, one multiplier bit per clock.
// Operands are accepted on an in_valid/in_ready handshake and the product is
// offered on an out_valid/out_ready handshake. Signed mode multiplies
// magnitudes and fixes the sign in a single correction cycle.
// Optional build macro: MUL_SEQ_HI_PRODUCT_EN adds the P_HI output (upper
// WIDTH bits of the full product).
module mul_seq_nbit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] P,
`ifdef MUL_SEQ_HI_PRODUCT_EN
    output logic [WIDTH-1:0] P_HI,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Unsigned magnitude; the most negative value maps onto 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        if (sgn && v[WIDTH-1]) begin
            return ~v + WIDTH'(1);
        end else begin
            return v;
        end
    endfunction

    state_t               state_r;
    state_t               state_nx_s;
    logic [2*WIDTH-1:0]   acc_r;      // upper half: partial sum, lower half: multiplier bits
    logic [WIDTH-1:0]     mcand_r;
    logic                 neg_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     p_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic                 last_bit_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH-1:0]     prod_lo_s;
`ifdef MUL_SEQ_HI_PRODUCT_EN
    logic [WIDTH-1:0]     p_hi_r;
    logic [2*WIDTH-1:0]   prod_s;
`endif

    assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

    // Next-state logic for the IDLE -> BUSY -> FIX -> DONE sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_bit_s) begin
                    state_nx_s = ST_FIX;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_FIX: begin
                state_nx_s = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Handshake/status outputs registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
            busy_r      <= (state_nx_s == ST_BUSY) || (state_nx_s == ST_FIX);
        end
    end

    // One shift-add step: add the multiplicand when the current multiplier LSB is set.
    always_comb begin
        sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        if (acc_r[0]) begin
            sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
    end

`ifdef MUL_SEQ_HI_PRODUCT_EN
    // Sign correction over the full double-width product.
    always_comb begin
        prod_s = acc_r;
        if (neg_r) begin
            prod_s = ~acc_r + (2*WIDTH)'(1);
        end else begin
            prod_s = acc_r;
        end
        prod_lo_s = prod_s[WIDTH-1:0];
    end
`else
    // Sign correction of the low half only; the low bits of a negation do not depend on the high bits.
    always_comb begin
        prod_lo_s = acc_r[WIDTH-1:0];
        if (neg_r) begin
            prod_lo_s = ~acc_r[WIDTH-1:0] + WIDTH'(1);
        end else begin
            prod_lo_s = acc_r[WIDTH-1:0];
        end
    end
`endif

    // Datapath: operand latch, iterative accumulate/shift, and result capture in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= '0;
            mcand_r <= '0;
            neg_r   <= 1'b0;
            cnt_r   <= '0;
            p_r     <= '0;
`ifdef MUL_SEQ_HI_PRODUCT_EN
            p_hi_r  <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand_r <= magnitude(A, is_signed);
                        acc_r   <= {{WIDTH{1'b0}}, magnitude(B, is_signed)};
                        neg_r   <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= '0;
                    end
                end
                ST_BUSY: begin
                    acc_r <= {sum_s, acc_r[WIDTH-1:1]};
                    if (last_bit_s) begin
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    p_r    <= prod_lo_s;
`ifdef MUL_SEQ_HI_PRODUCT_EN
                    p_hi_r <= prod_s[2*WIDTH-1:WIDTH];
`endif
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign P         = p_r;
`ifdef MUL_SEQ_HI_PRODUCT_EN
    assign P_HI      = p_hi_r;
`endif

endmodule
